// File: rtl/addsub_pkg.sv
// Shared constants and types for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index; a single nibble still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_nibble.sv
// 4-bit controlled adder/subtractor slice: s = a + (b ^ {4{sub}}) + cin.
module addsub_nibble
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] w_b_inv;
  logic [NIBBLE_W:0]   w_sum;

  // Invert B for subtraction; the +1 comes in through cin on the first nibble.
  always_comb begin
    w_b_inv = b ^ {NIBBLE_W{sub}};
    w_sum   = {1'b0, a} + {1'b0, w_b_inv} + {{NIBBLE_W{1'b0}}, cin};
    s       = w_sum[NIBBLE_W-1:0];
    cout    = w_sum[NIBBLE_W];
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Wide add/subtract sequenced one nibble per cycle through a single 4-bit
// slice, LSB first, with the carry chained in a register between nibbles.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  input  logic                      op_sub,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                      res_cout,
  output logic                      res_ovf,
  output logic                      busy
);

  localparam int IW = idx_w(NIBBLES);

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_b;
  logic                               r_sub;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_result;
  logic [IW-1:0]                      r_idx;
  logic                               r_carry;
  logic                               r_cout;
  logic                               r_ovf;

  logic [NIBBLE_W-1:0]                w_a_nib;
  logic [NIBBLE_W-1:0]                w_b_nib;
  logic [NIBBLE_W-1:0]                w_s;
  logic                               w_cout;
  logic                               w_last;
  logic                               w_accept;

  // Current nibble selection and end-of-operand detection.
  always_comb begin
    w_a_nib  = r_a[r_idx];
    w_b_nib  = r_b[r_idx];
    w_last   = (r_idx == IW'(NIBBLES - 1));
    w_accept = (r_state == IDLE) && start_valid;
  end

  addsub_nibble u_nibble (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .sub  (r_sub),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: accept in IDLE, step through nibbles, hold result until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_valid) w_state_nxt = RUN;
      RUN:     if (w_last)      w_state_nxt = DONE;
      DONE:    if (res_ready)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    start_ready = (r_state == IDLE);
    res_valid   = (r_state == DONE);
    busy        = (r_state != IDLE);
  end

  // Operand latch, per-nibble result write, carry chain and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= op_a;
      r_b      <= op_b;
      r_sub    <= op_sub;
      r_carry  <= op_sub;
      r_idx    <= '0;
      r_result <= '0;
    end else if (r_state == RUN) begin
      r_result[r_idx] <= w_s;
      r_carry         <= w_cout;
      r_idx           <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_cout;
        // Signed overflow: operand signs agree but the result sign differs.
        r_ovf  <= (w_a_nib[NIBBLE_W-1] == (w_b_nib[NIBBLE_W-1] ^ r_sub)) &&
                  (w_s[NIBBLE_W-1] != w_a_nib[NIBBLE_W-1]);
      end
    end
  end

  assign result   = r_result;
  assign res_cout = r_cout;
  assign res_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed checks of serial_addsub_ctrl against an
// arithmetic reference model.
module tb_serial_addsub_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .res_cout(res_cout), .res_ovf(res_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the definition of +/- on W-bit values.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] r, output logic c, output logic v);
    longint sa, sb, sd;
    logic [W:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r  = a - b;
      c  = (a >= b);
      sd = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r  = full[W-1:0];
      c  = full[W];
      sd = sa + sb;
    end
    v = (sd > (2**(W-1)) - 1) || (sd < -(2**(W-1)));
  endfunction

  // Model: one request in flight, result due N edges after acceptance.
  bit           m_active = 0;
  int           m_left   = 0;
  logic [W-1:0] m_res    = '0;
  logic         m_cout   = 1'b0;
  logic         m_ovf    = 1'b0;
  bit           m_held   = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_left = 0; m_res = '0; m_cout = 0; m_ovf = 0; m_held = 1;
    end else if (!m_active) begin
      if (start_valid) begin
        ref_op(op_a, op_b, op_sub, m_res, m_cout, m_ovf);
        m_active = 1; m_left = N; m_held = 0;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (res_ready) begin
      m_active = 0; m_held = 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_start_ready", {31'b0, start_ready}, 1);
      chk("rst_res_valid", {31'b0, res_valid}, 0);
      chk("rst_result", {16'b0, result}, 0);
      chk("rst_cout_ovf", {30'b0, res_cout, res_ovf}, 0);
    end else begin
      chk("res_valid", {31'b0, res_valid}, {31'b0, (m_active && m_left == 0)});
      chk("start_ready", {31'b0, start_ready}, {31'b0, !m_active});
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      if ((m_active && m_left == 0) || (!m_active && m_held)) begin
        chk("result", {16'b0, result}, {16'b0, m_res});
        chk("cout", {31'b0, res_cout}, {31'b0, m_cout});
        chk("ovf", {31'b0, res_ovf}, {31'b0, m_ovf});
      end
    end
  end

  // Directed op with literal expectations and a latency check.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] er, input logic ec, input logic ev);
    int lat;
    op_a = a; op_b = b; op_sub = sub; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a = ~a; op_b = ~b; op_sub = ~sub;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = k; break; end
    end
    chk("latency", lat, N);
    chk("lit_result", {16'b0, result}, {16'b0, er});
    chk("lit_cout", {31'b0, res_cout}, {31'b0, ec});
    chk("lit_ovf", {31'b0, res_ovf}, {31'b0, ev});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0000, 16'h0005, 0, 16'h0005, 0, 0);
    run_op(16'h000F, 16'h0001, 0, 16'h0010, 0, 0);
    run_op(16'h0000, 16'h0005, 1, 16'hFFFB, 0, 0);
    run_op(16'h0005, 16'h0000, 1, 16'h0005, 1, 0);
    run_op(16'hFFFF, 16'hFFFF, 0, 16'hFFFE, 1, 0);
    run_op(16'hFFFF, 16'hFFFF, 1, 16'h0000, 1, 0);
    run_op(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    run_op(16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);

    // Back-pressure with a competing request held valid throughout.
    op_a = 16'h1000; op_b = 16'h0234; op_sub = 0; start_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h4000; op_b = 16'h0001; op_sub = 1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = k; break; end
    end
    chk("bp_latency", lat, N);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_held_result", {16'b0, result}, 32'h1234);
      chk("bp_start_ready", {31'b0, start_ready}, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_idle", {31'b0, start_ready}, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("bp_accepted", {31'b0, busy}, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = k; break; end
    end
    chk("bp2_latency", lat, N);
    chk("bp2_result", {16'b0, result}, 32'h3FFF);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset while two nibbles into RUN.
    op_a = 16'hABCD; op_b = 16'h1111; op_sub = 0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, res_valid}, 0);
    chk("mid_rst_result", {16'b0, result}, 0);
    chk("mid_rst_ready", {31'b0, start_ready}, 1);
    repeat (N + 2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h1234, 16'h1111, 0, 16'h2345, 0, 0);

    // Random traffic with random gaps and back-pressure; the model checks it.
    for (int c = 0; c < 3000; c++) begin
      start_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: op_a = 16'h7FFF;
        1: op_a = 16'h8000;
        default: op_a = W'($urandom);
      endcase
      op_b = ($urandom_range(0, 3) == 0) ? op_a : W'($urandom);
      op_sub = $urandom_range(0, 1) == 1;
      res_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    repeat (N + 3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
